game_session_ctrl: RTL and testbench
====================================

// Module: game_session_ctrl
// PURPOSE
//   Parametrised game-session controller for the Deadline game: owns the round FSM, N_HW
//   homework pickups plus one gold pickup, the countdown deadline and win/lose decision.
//   Sits between the position logic (player/item coordinates) and drawcon/multidigit/PWM,
//   replacing fixed 3-item flag wiring with a packed N_HW-channel interface.
//   All state advances only on frame_tick (one-cycle pulse per 60 Hz frame in the clk domain).
// PARAMETERS
//   N_HW        3    number of homework pickups (1..8)
//   X_W         11   x coordinate width
//   Y_W         10   y coordinate width
//   SPR_W       32   sprite edge length in pixels (player and pickups are SPR_W x SPR_W)
//   TIME_SEC    60   base round time in seconds (10..99)
//   TICKS_SEC   60   frame_ticks per second
//   GOLD_BONUS  5    seconds added on gold pickup
// PORTS
//   clk          in   1          system clock
//   rst          in   1          synchronous reset, active-low
//   frame_tick   in   1          one-cycle frame strobe
//   start        in   1          level; rising edge (sampled on frame_tick) starts/restarts a round
//   pause        in   1          level; rising edge (sampled on frame_tick) toggles PLAY<->PAUSE
//   diff         in   3          difficulty; round time = max(TIME_SEC-10*diff, 10)
//   player_x/y   in   X_W/Y_W    player top-left
//   item_x       in   N_HW*X_W   packed pickup x, item i at [i*X_W +: X_W]
//   item_y       in   N_HW*Y_W   packed pickup y
//   gold_x/y     in   X_W/Y_W    gold top-left
//   state        out  3          IDLE=0 PLAY=1 PAUSE=2 WIN=3 LOSE=4
//   collected    out  N_HW       per-item disappear flags
//   gold_taken   out  1          gold disappear flag
//   score        out  4          count of set collected bits
//   time_bcd     out  8          seconds left, {tens,units} BCD
//   warn         out  2          00 normal, 01 time<=20, 10 time<=10 (to PWM reminder LEDs)
//   win, lose    out  1          level, high in WIN / LOSE respectively
// BEHAVIOUR
//   - Reset (rst=0 at clk edge): state=IDLE, collected=0, gold_taken=0, score=0, time_bcd=0x00,
//     warn=00, win=lose=0, tick counter=0, edge-detect registers=0. Reset mid-round discards round.
//   - All transitions/updates occur on an edge where frame_tick=1; outputs registered, change
//     on that edge (1-cycle latency from the sampled frame). No change when frame_tick=0.
//   - IDLE --start rise--> PLAY: load time_bcd from diff, clear collected/gold/score/tick count.
//   - PLAY: pause rise -> PAUSE (timer and collisions frozen). PAUSE: pause rise -> PLAY.
//   - WIN/LOSE: hold all outputs; start rise -> PLAY with fresh load (same as from IDLE).
//   - start rise takes priority over pause rise in every state.
//   - Collision (PLAY only): overlap iff px < ix+SPR_W && ix < px+SPR_W && py < iy+SPR_W &&
//     iy < py+SPR_W; sums computed at X_W+1 / Y_W+1 bits (no wrap). Edge-touching is not overlap.
//   - Uncollected items that overlap set their bit; several items in one frame all set.
//     Set bits are sticky until round load. score = popcount(next collected).
//   - Gold overlap with gold_taken=0: gold_taken=1, time += GOLD_BONUS, saturate at 99.
//   - Timer: tick counter 0..TICKS_SEC-1 in PLAY; at TICKS_SEC-1 wraps to 0 and time_bcd
//     decrements in BCD (e.g. 0x10 -> 0x09). Gold bonus and decrement in same frame: apply both.
//   - End: if next collected is all ones -> WIN. Else if time reaches 0x00 -> LOSE.
//     Last item and time reaching 0 in the same frame -> WIN (win has priority).
//   - warn from current time_bcd in PLAY/PAUSE; 00 in IDLE/WIN/LOSE.
// TESTING
//   1. rst=0 two edges then release -> all outputs at reset values, state=0; no frame_tick -> no change.
//   2. diff=2, start rise -> state=1, time_bcd=0x40; 60 ticks -> 0x39; diff=7 -> load 0x10.
//   3. player over item1 only (N_HW=3) -> collected=3'b010, score=1 next edge; overlap again -> unchanged.
//   4. items 0 and 2 overlapped in one frame after item1 -> collected=3'b111, state=3, win=1.
//   5. time 0x97, gold hit -> 0x99; let time run to 0x00 with items missing -> state=4, lose=1, warn=00.
//   6. pause rise in PLAY -> state=2, time_bcd frozen 120 ticks; pause+start rise together -> state=1, reloaded.

Source files
------------

// File: rtl/game_session_ctrl.sv
// Deadline game round controller: FSM, N_HW homework pickups + gold, countdown timer, win/lose.
// State advances only on frame_tick; outputs registered, 1-cycle latency from the sampled frame.
module game_session_ctrl #(
  parameter int N_HW       = 3,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int SPR_W      = 32,
  parameter int TIME_SEC   = 60,
  parameter int TICKS_SEC  = 60,
  parameter int GOLD_BONUS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start,
  input  logic                pause,
  input  logic [2:0]          diff,
  input  logic [X_W-1:0]      player_x,
  input  logic [Y_W-1:0]      player_y,
  input  logic [N_HW*X_W-1:0] item_x,
  input  logic [N_HW*Y_W-1:0] item_y,
  input  logic [X_W-1:0]      gold_x,
  input  logic [Y_W-1:0]      gold_y,
  output logic [2:0]          state,
  output logic [N_HW-1:0]     collected,
  output logic                gold_taken,
  output logic [3:0]          score,
  output logic [7:0]          time_bcd,
  output logic [1:0]          warn,
  output logic                win,
  output logic                lose
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  localparam int XE = X_W + 1;
  localparam int YE = Y_W + 1;
  localparam int TW = $clog2(TICKS_SEC + 1);
  localparam logic [XE-1:0] SPR_X    = XE'(SPR_W);
  localparam logic [YE-1:0] SPR_Y    = YE'(SPR_W);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_SEC - 1);
  localparam logic [7:0]    BONUS8   = 8'(GOLD_BONUS);
  localparam logic [7:0]    TS8      = 8'(TIME_SEC);

  logic          start_q, pause_q;
  logic [TW-1:0] tick_cnt;
  logic [6:0]    time_bin;

  logic          start_rise, pause_rise;
  logic [N_HW-1:0] hit_vec;
  logic          gold_hit;
  logic [2:0]    nxt_state;
  logic [N_HW-1:0] nxt_coll;
  logic          nxt_gold;
  logic [TW-1:0] nxt_tick;
  logic [6:0]    nxt_time;
  logic          bonus, wrap;
  logic [7:0]    sum;

  // Sums are widened one bit so sprites near the far edge cannot wrap into a false hit
  function automatic logic overlap(input logic [X_W-1:0] px, input logic [X_W-1:0] ix,
                                   input logic [Y_W-1:0] py, input logic [Y_W-1:0] iy);
    logic [XE-1:0] pxe, ixe;
    logic [YE-1:0] pye, iye;
    pxe = {1'b0, px};
    ixe = {1'b0, ix};
    pye = {1'b0, py};
    iye = {1'b0, iy};
    return (pxe < ixe + SPR_X) && (ixe < pxe + SPR_X) &&
           (pye < iye + SPR_Y) && (iye < pye + SPR_Y);
  endfunction

  function automatic logic [6:0] load_time(input logic [2:0] d);
    logic [7:0] d10;
    logic [7:0] t;
    d10 = {2'b0, d, 3'b0} + {4'b0, d, 1'b0};
    if (TS8 >= d10 + 8'd10) t = TS8 - d10;
    else                    t = 8'd10;
    return t[6:0];
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] r;
    tens = 4'd0;
    r    = v;
    for (int k = 0; k < 9; k++) begin
      if (r >= 7'd10) begin
        r    = r - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, r[3:0]};
  endfunction

  function automatic logic [3:0] popcount(input logic [N_HW-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < N_HW; k++) c = c + {3'b0, v[k]};
    return c;
  endfunction

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_HW; i++) begin
      hit_vec[i] = overlap(player_x, item_x[i*X_W +: X_W], player_y, item_y[i*Y_W +: Y_W]);
    end
    gold_hit = overlap(player_x, gold_x, player_y, gold_y);
  end

  always_comb begin
    nxt_state = state;
    nxt_coll  = collected;
    nxt_gold  = gold_taken;
    nxt_tick  = tick_cnt;
    nxt_time  = time_bin;
    bonus     = 1'b0;
    wrap      = 1'b0;
    sum       = 8'd0;
    if (start_rise) begin
      nxt_state = S_PLAY;
      nxt_coll  = '0;
      nxt_gold  = 1'b0;
      nxt_tick  = '0;
      nxt_time  = load_time(diff);
    end else begin
      case (state)
        S_PLAY: begin
          if (pause_rise) begin
            nxt_state = S_PAUSE;
          end else begin
            nxt_coll = collected | hit_vec;
            bonus    = gold_hit & ~gold_taken;
            if (bonus) nxt_gold = 1'b1;
            wrap     = (tick_cnt == TICK_MAX);
            nxt_tick = wrap ? '0 : tick_cnt + TW'(1);
            // Bonus and decrement in the same frame both apply; saturate afterwards
            sum = {1'b0, time_bin} + (bonus ? BONUS8 : 8'd0);
            if (wrap) sum = sum - 8'd1;
            if (sum > 8'd99) sum = 8'd99;
            nxt_time = sum[6:0];
            if (&nxt_coll)             nxt_state = S_WIN;
            else if (nxt_time == 7'd0) nxt_state = S_LOSE;
          end
        end
        S_PAUSE: begin
          if (pause_rise) nxt_state = S_PLAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      state      <= S_IDLE;
      collected  <= '0;
      gold_taken <= 1'b0;
      tick_cnt   <= '0;
      time_bin   <= 7'd0;
      time_bcd   <= 8'h00;
      score      <= 4'd0;
    end else if (frame_tick) begin
      start_q    <= start;
      pause_q    <= pause;
      state      <= nxt_state;
      collected  <= nxt_coll;
      gold_taken <= nxt_gold;
      tick_cnt   <= nxt_tick;
      time_bin   <= nxt_time;
      time_bcd   <= to_bcd(nxt_time);
      score      <= popcount(nxt_coll);
    end
  end

  always_comb begin
    warn = 2'b00;
    if (state == S_PLAY || state == S_PAUSE) begin
      if (time_bin <= 7'd10)      warn = 2'b10;
      else if (time_bin <= 7'd20) warn = 2'b01;
    end
  end

  assign win  = (state == S_WIN);
  assign lose = (state == S_LOSE);

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench: default instance plus a 99 s / 4-tick instance for saturation and timeout.
module tb_game_session_ctrl;
  logic        clk = 1'b0;
  logic        rst, frame_tick, start, pause;
  logic [2:0]  diff;
  logic [10:0] player_x, gold_x;
  logic [9:0]  player_y, gold_y;
  logic [32:0] item_x;
  logic [29:0] item_y;

  logic [2:0] state, s2_state;
  logic [2:0] collected, s2_collected;
  logic       gold_taken, s2_gold_taken;
  logic [3:0] score, s2_score;
  logic [7:0] time_bcd, s2_time_bcd;
  logic [1:0] warn, s2_warn;
  logic       win, lose, s2_win, s2_lose;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_session_ctrl u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause), .diff(diff),
    .player_x(player_x), .player_y(player_y), .item_x(item_x), .item_y(item_y),
    .gold_x(gold_x), .gold_y(gold_y), .state(state), .collected(collected),
    .gold_taken(gold_taken), .score(score), .time_bcd(time_bcd), .warn(warn),
    .win(win), .lose(lose)
  );

  game_session_ctrl #(.TIME_SEC(99), .TICKS_SEC(4)) u_d99 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause), .diff(diff),
    .player_x(player_x), .player_y(player_y), .item_x(item_x), .item_y(item_y),
    .gold_x(gold_x), .gold_y(gold_y), .state(s2_state), .collected(s2_collected),
    .gold_taken(s2_gold_taken), .score(s2_score), .time_bcd(s2_time_bcd), .warn(s2_warn),
    .win(s2_win), .lose(s2_lose)
  );

  task automatic frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic set_item(input int i, input int x, input int y);
    item_x[i*11 +: 11] = 11'(x);
    item_y[i*10 +: 10] = 10'(y);
  endtask

  task automatic park();
    set_item(0, 400, 300);
    set_item(1, 500, 300);
    set_item(2, 600, 300);
    gold_x = 11'd700; gold_y = 10'd300;
    player_x = 11'd0; player_y = 10'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; diff = 3'd0;
    park();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    checks++;
    if ({state, collected, gold_taken, score, time_bcd, warn, win, lose} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d coll=%b gold=%b score=%0d time=%h warn=%b win=%b lose=%b (need all 0)",
               state, collected, gold_taken, score, time_bcd, warn, win, lose);
    end
    start = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL no_tick_no_change: state=%0d need 0", state);
    end
    start = 1'b0;
  endtask

  task automatic test_load();
    diff = 3'd2; start = 1'b1; frame(); start = 1'b0;
    checks++;
    if (state !== 3'd1 || time_bcd !== 8'h40 || score !== 4'd0) begin
      errors++; $display("FAIL load_diff2: state=%0d time=%h score=%0d need 1/40/0", state, time_bcd, score);
    end
    repeat (59) frame();
    checks++;
    if (time_bcd !== 8'h40) begin
      errors++; $display("FAIL tick_59: time=%h need 40", time_bcd);
    end
    frame();
    checks++;
    if (time_bcd !== 8'h39) begin
      errors++; $display("FAIL bcd_decrement: time=%h need 39", time_bcd);
    end
    diff = 3'd7; start = 1'b1; frame(); start = 1'b0;
    checks++;
    if (state !== 3'd1 || time_bcd !== 8'h10 || warn !== 2'b10) begin
      errors++; $display("FAIL load_diff7: state=%0d time=%h warn=%b need 1/10/10", state, time_bcd, warn);
    end
  endtask

  task automatic test_collect();
    player_x = 11'd500; player_y = 10'd300; frame();
    checks++;
    if (collected !== 3'b010 || score !== 4'd1) begin
      errors++; $display("FAIL collect_item1: coll=%b score=%0d need 010/1", collected, score);
    end
    frame();
    checks++;
    if (collected !== 3'b010 || score !== 4'd1 || state !== 3'd1) begin
      errors++; $display("FAIL collect_sticky: coll=%b score=%0d state=%0d need 010/1/1", collected, score, state);
    end
    player_x = 11'd432; player_y = 10'd300; frame();
    player_x = 11'd400; player_y = 10'd268; frame();
    checks++;
    if (collected !== 3'b010) begin
      errors++; $display("FAIL edge_touch: coll=%b need 010", collected);
    end
  endtask

  task automatic test_win();
    set_item(0, 200, 200); set_item(2, 210, 210);
    player_x = 11'd205; player_y = 10'd205; frame();
    checks++;
    if (collected !== 3'b111 || score !== 4'd3 || state !== 3'd3 || win !== 1'b1 || lose !== 1'b0) begin
      errors++; $display("FAIL win: coll=%b score=%0d state=%0d win=%b lose=%b need 111/3/3/1/0",
                         collected, score, state, win, lose);
    end
    repeat (70) frame();
    checks++;
    if (state !== 3'd3 || time_bcd !== 8'h10 || warn !== 2'b00) begin
      errors++; $display("FAIL win_hold: state=%0d time=%h warn=%b need 3/10/00", state, time_bcd, warn);
    end
    park();
  endtask

  task automatic test_gold_lose();
    int n;
    logic [1:0] exp_w;
    diff = 3'd0; start = 1'b1; frame(); start = 1'b0;
    repeat (8) frame();
    checks++;
    if (s2_time_bcd !== 8'h97 || s2_state !== 3'd1) begin
      errors++; $display("FAIL pre_gold: time=%h state=%0d need 97/1", s2_time_bcd, s2_state);
    end
    player_x = 11'd710; player_y = 10'd290; frame();
    checks++;
    if (s2_time_bcd !== 8'h99 || s2_gold_taken !== 1'b1) begin
      errors++; $display("FAIL gold_saturate: time=%h gold=%b need 99/1", s2_time_bcd, s2_gold_taken);
    end
    checks++;
    if (time_bcd !== 8'h65 || gold_taken !== 1'b1) begin
      errors++; $display("FAIL gold_bonus: time=%h gold=%b need 65/1", time_bcd, gold_taken);
    end
    player_x = 11'd0; player_y = 10'd0;
    n = 0;
    while (s2_state == 3'd1 && n < 1000) begin
      frame();
      n++;
      exp_w = (s2_time_bcd == 8'h00) ? 2'b00 : (s2_time_bcd <= 8'h10) ? 2'b10 :
              (s2_time_bcd <= 8'h20) ? 2'b01 : 2'b00;
      checks++;
      if (s2_warn !== exp_w) begin
        errors++; $display("FAIL warn_level: time=%h warn=%b need %b", s2_time_bcd, s2_warn, exp_w);
      end
    end
    checks++;
    if (n !== 395) begin
      errors++; $display("FAIL lose_frames: frames=%0d need 395", n);
    end
    checks++;
    if (s2_state !== 3'd4 || s2_lose !== 1'b1 || s2_win !== 1'b0 || s2_warn !== 2'b00 ||
        s2_time_bcd !== 8'h00 || s2_collected !== 3'b000) begin
      errors++; $display("FAIL lose: state=%0d lose=%b win=%b warn=%b time=%h coll=%b need 4/1/0/00/00/000",
                         s2_state, s2_lose, s2_win, s2_warn, s2_time_bcd, s2_collected);
    end
  endtask

  task automatic test_pause();
    diff = 3'd1; start = 1'b1; frame(); start = 1'b0;
    repeat (30) frame();
    pause = 1'b1; frame(); pause = 1'b0;
    checks++;
    if (state !== 3'd2 || time_bcd !== 8'h50) begin
      errors++; $display("FAIL pause_enter: state=%0d time=%h need 2/50", state, time_bcd);
    end
    repeat (120) frame();
    checks++;
    if (state !== 3'd2 || time_bcd !== 8'h50) begin
      errors++; $display("FAIL pause_frozen: state=%0d time=%h need 2/50", state, time_bcd);
    end
    pause = 1'b1; frame(); pause = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL pause_exit: state=%0d need 1", state);
    end
    repeat (29) frame();
    checks++;
    if (time_bcd !== 8'h50) begin
      errors++; $display("FAIL tick_preserved_pre: time=%h need 50", time_bcd);
    end
    frame();
    checks++;
    if (time_bcd !== 8'h49) begin
      errors++; $display("FAIL tick_preserved: time=%h need 49", time_bcd);
    end
    pause = 1'b1; frame(); pause = 1'b0; frame();
    diff = 3'd3; pause = 1'b1; start = 1'b1; frame(); pause = 1'b0; start = 1'b0;
    checks++;
    if (state !== 3'd1 || time_bcd !== 8'h30) begin
      errors++; $display("FAIL start_over_pause: state=%0d time=%h need 1/30", state, time_bcd);
    end
  endtask

  task automatic test_back_to_back();
    frame();
    diff = 3'd0; start = 1'b1; frame(); start = 1'b0;
    checks++;
    if (state !== 3'd1 || time_bcd !== 8'h60 || warn !== 2'b00) begin
      errors++; $display("FAIL restart_in_play: state=%0d time=%h warn=%b need 1/60/00", state, time_bcd, warn);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    checks++;
    if (state !== 3'd0 || time_bcd !== 8'h00 || gold_taken !== 1'b0) begin
      errors++; $display("FAIL mid_round_reset: state=%0d time=%h gold=%b need 0/00/0", state, time_bcd, gold_taken);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_collect();
    test_win();
    test_gold_lose();
    test_pause();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
